// File: rtl/dino_pkg.sv
// dino_pkg
// Shared types and constants for the dino runner game controller.
//   game_state_e : top-level game phase (IDLE=0, RUN=1, OVER=2), also the
//                  encoding seen on the game_state output port
//   jump_state_e : vertical motion phase of the dino (GROUND/RISE/FALL)
//   DEF_*        : default values for the controller parameters
//   LFSR_SEED    : start value of the obstacle-enable LFSR
//   lfsr_next()  : one step of the x^3+x^2+1 LFSR
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    typedef enum logic [1:0] {
        JS_GROUND = 2'd0,
        JS_RISE   = 2'd1,
        JS_FALL   = 2'd2
    } jump_state_e;

    localparam int DEF_JUMP_MAX    = 50;
    localparam int DEF_JUMP_STEP   = 2;
    localparam int DEF_SCROLL_MAX  = 300;
    localparam int DEF_SCROLL_STEP = 4;

    localparam logic [2:0] LFSR_SEED = 3'b001;

    // Fibonacci form, shifting left: feedback bit is tap3 ^ tap2.
    // From the seed this walks 001->010->101->011->111->110->100->001.
    function automatic logic [2:0] lfsr_next(input logic [2:0] cur);
        return {cur[1:0], cur[2] ^ cur[1]};
    endfunction

endpackage

// File: rtl/dino_jump_fsm.sv
// dino_jump_fsm
// Vertical motion of the dino: GROUND/RISE/FALL machine plus the height
// register.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : force GROUND with zero height (new game starting)
//   advance     : one frame of motion (frame tick while the game runs)
//   jump_req    : pending jump request, only acted on from GROUND
//   dino_yoff   : current lift above ground, 0..JUMP_MAX
module dino_jump_fsm
    import dino_pkg::*;
#(
    parameter int JUMP_MAX  = DEF_JUMP_MAX,
    parameter int JUMP_STEP = DEF_JUMP_STEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic       jump_req,
    output logic [9:0] dino_yoff
);

    localparam logic [10:0] MAX_W  = 11'(JUMP_MAX);
    localparam logic [10:0] STEP_W = 11'(JUMP_STEP);

    jump_state_e state_q, state_d;
    logic [9:0]  yoff_q, yoff_d;
    logic [10:0] lift_sum;

    // One bit wider than the height so the clamp compare cannot wrap.
    assign lift_sum = {1'b0, yoff_q} + STEP_W;

    // Next-state/height. Take-off from GROUND already lifts the dino on the
    // same frame, so a full jump is JUMP_MAX/JUMP_STEP frames up and the
    // same number down.
    always_comb begin
        state_d = state_q;
        yoff_d  = yoff_q;
        if (clear) begin
            state_d = JS_GROUND;
            yoff_d  = '0;
        end else if (advance) begin
            case (state_q)
                JS_GROUND, JS_RISE: begin
                    if (state_q == JS_RISE || jump_req) begin
                        if (lift_sum >= MAX_W) begin
                            yoff_d  = MAX_W[9:0];
                            state_d = JS_FALL;
                        end else begin
                            yoff_d  = lift_sum[9:0];
                            state_d = JS_RISE;
                        end
                    end
                end
                JS_FALL: begin
                    // Compare before subtracting so the height never underflows.
                    if ({1'b0, yoff_q} <= STEP_W) begin
                        yoff_d  = '0;
                        state_d = JS_GROUND;
                    end else begin
                        yoff_d = yoff_q - STEP_W[9:0];
                    end
                end
                default: begin
                    state_d = JS_GROUND;
                    yoff_d  = '0;
                end
            endcase
        end
    end

    // State and height registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= JS_GROUND;
            yoff_q  <= '0;
        end else begin
            state_q <= state_d;
            yoff_q  <= yoff_d;
        end
    end

    assign dino_yoff = yoff_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl
// Game controller for the dino runner: button edge detection, the
// IDLE/RUN/OVER game machine, obstacle scrolling, score and obstacle
// enables. The jump motion lives in dino_jump_fsm.
// Ports:
//   clk, rst_n   : pixel clock, synchronous active-low reset
//   frame_tick   : one-cycle pulse per video frame; paces all updates
//   jump_btn     : jump/start button level (already synchronized)
//   restart_btn  : restart button level (already synchronized)
//   collision    : dino/obstacle overlap, ends a running game at once
//   game_state   : IDLE=0, RUN=1, OVER=2
//   dino_yoff    : dino lift above ground
//   obst_x       : obstacle scroll offset, 0..SCROLL_MAX
//   obst_en      : obstacle enables b1..b3
//   score        : obstacles passed, saturating at 1023
// Build option: define DINO_SPEEDUP_EN to speed the scroll up with the
// score (step = SCROLL_STEP + min(score>>4, 3)); otherwise the step is fixed.
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int JUMP_MAX    = DEF_JUMP_MAX,
    parameter int JUMP_STEP   = DEF_JUMP_STEP,
    parameter int SCROLL_MAX  = DEF_SCROLL_MAX,
    parameter int SCROLL_STEP = DEF_SCROLL_STEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       jump_btn,
    input  logic       restart_btn,
    input  logic       collision,
    output logic [1:0] game_state,
    output logic [9:0] dino_yoff,
    output logic [9:0] obst_x,
    output logic [2:0] obst_en,
    output logic [9:0] score
);

    localparam logic [10:0] SCROLL_MAX_W  = 11'(SCROLL_MAX);
    localparam logic [10:0] SCROLL_STEP_W = 11'(SCROLL_STEP);

    game_state_e state_q, state_d;
    logic [9:0]  obst_x_q, obst_x_d;
    logic [9:0]  score_q, score_d;
    logic [2:0]  obst_en_q, obst_en_d;
    logic [2:0]  lfsr_q, lfsr_d, lfsr_adv;
    logic        jump_req_q, jump_req_d;
    logic        restart_req_q, restart_req_d;
    logic        jump_prev_q, restart_prev_q;
    logic        jump_rise, restart_rise;
    logic        jump_clear, jump_advance;
    logic [10:0] step;
    logic [10:0] scroll_sum;

    assign jump_rise    = jump_btn & ~jump_prev_q;
    assign restart_rise = restart_btn & ~restart_prev_q;

`ifdef DINO_SPEEDUP_EN
    logic [1:0] bonus;
    // min(score>>4, 3): any of score[9:6] set means the shifted value exceeds 3.
    assign bonus = (score_q[9:4] > 6'd3) ? 2'd3 : score_q[5:4];
    assign step  = SCROLL_STEP_W + {9'd0, bonus};
`else
    assign step = SCROLL_STEP_W;
`endif

    assign scroll_sum = {1'b0, obst_x_q} + step;
    assign lfsr_adv   = lfsr_next(lfsr_q);

    // Game machine and scroll bookkeeping. Everything waits for a frame tick
    // except the RUN->OVER step, which follows a collision immediately and
    // also blocks that frame's scroll, score and jump update.
    always_comb begin
        state_d      = state_q;
        obst_x_d     = obst_x_q;
        score_d      = score_q;
        obst_en_d    = obst_en_q;
        lfsr_d       = lfsr_q;
        jump_clear   = 1'b0;
        jump_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && jump_req_q) begin
                    state_d    = ST_RUN;
                    obst_x_d   = '0;
                    score_d    = '0;
                    obst_en_d  = 3'b001;
                    jump_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    state_d = ST_OVER;
                end else if (frame_tick) begin
                    jump_advance = 1'b1;
                    if (scroll_sum > SCROLL_MAX_W) begin
                        obst_x_d  = '0;
                        score_d   = (score_q == 10'd1023) ? score_q : score_q + 10'd1;
                        lfsr_d    = lfsr_adv;
                        obst_en_d = (lfsr_adv == 3'b000) ? 3'b001 : lfsr_adv;
                    end else begin
                        obst_x_d = scroll_sum[9:0];
                    end
                end
            end
            ST_OVER: begin
                if (frame_tick && restart_req_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick consumes (or, mid-jump, discards) the request held before it;
        // an edge arriving on the tick cycle itself survives to the next tick.
        // OVER drops jump requests and only OVER keeps restart requests.
        if (state_q == ST_OVER) begin
            jump_req_d    = 1'b0;
            restart_req_d = (restart_req_q & ~frame_tick) | restart_rise;
        end else begin
            jump_req_d    = (jump_req_q & ~frame_tick) | jump_rise;
            restart_req_d = 1'b0;
        end
    end

    // All controller registers, including the button history for edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            obst_x_q       <= '0;
            score_q        <= '0;
            obst_en_q      <= 3'b001;
            lfsr_q         <= LFSR_SEED;
            jump_req_q     <= 1'b0;
            restart_req_q  <= 1'b0;
            jump_prev_q    <= 1'b0;
            restart_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            obst_x_q       <= obst_x_d;
            score_q        <= score_d;
            obst_en_q      <= obst_en_d;
            lfsr_q         <= lfsr_d;
            jump_req_q     <= jump_req_d;
            restart_req_q  <= restart_req_d;
            jump_prev_q    <= jump_btn;
            restart_prev_q <= restart_btn;
        end
    end

    dino_jump_fsm #(
        .JUMP_MAX  (JUMP_MAX),
        .JUMP_STEP (JUMP_STEP)
    ) u_jump_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (jump_clear),
        .advance   (jump_advance),
        .jump_req  (jump_req_q),
        .dino_yoff (dino_yoff)
    );

    assign game_state = state_q;
    assign obst_x     = obst_x_q;
    assign obst_en    = obst_en_q;
    assign score      = score_q;

endmodule

// File: doc/dino_game_ctrl.md
DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameter JUMP_MAX, default 50: peak dino jump height in pixels.
REQ-002 Parameter JUMP_STEP, default 2: jump height change per frame, in pixels.
REQ-003 Parameter SCROLL_MAX, default 300: obstacle scroll wrap limit, in pixels.
REQ-004 Parameter SCROLL_STEP, default 4: base obstacle scroll per frame, in pixels.
REQ-005 Port clk, input, 1 bit: single system clock, pixel clock domain.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-008 Port jump_btn, input, 1 bit: jump/start button, already synchronized, level.
REQ-009 Port restart_btn, input, 1 bit: restart button, already synchronized, level.
REQ-010 Port collision, input, 1 bit: dino/obstacle pixel overlap, valid any cycle.
REQ-011 Port game_state, output, 2 bits: IDLE=0, RUN=1, OVER=2.
REQ-012 Port dino_yoff, output, 10 bits: dino vertical lift above ground, 0..JUMP_MAX.
REQ-013 Port obst_x, output, 10 bits: obstacle scroll offset, 0..SCROLL_MAX.
REQ-014 Port obst_en, output, 3 bits: enables for obstacles b1..b3; never 0 in RUN.
REQ-015 Port score, output, 10 bits: count of obstacles passed, saturating.

Function
REQ-016 Edge detection: a rising edge on jump_btn sets jump_req, a rising edge on restart_btn sets restart_req; an edge seen in the same cycle as frame_tick is held for the next tick.
REQ-017 All state, offset, score and jump updates occur only on cycles with frame_tick=1, except the RUN->OVER transition.
REQ-018 IDLE + jump_req on tick -> RUN; clear score, obst_x and dino_yoff; set obst_en=3'b001; consume jump_req.
REQ-019 RUN + collision=1 in any cycle -> OVER on the next clock edge, without waiting for frame_tick.
REQ-020 OVER: freeze dino_yoff, obst_x, score and obst_en; clear jump_req; restart_req on tick -> IDLE.
REQ-021 Jump sub-FSM states are GROUND, RISE and FALL; it advances only in RUN.
REQ-022 GROUND + jump_req on tick -> RISE; jump_req is consumed.
REQ-023 RISE: dino_yoff += JUMP_STEP; if the result is >= JUMP_MAX, clamp dino_yoff to JUMP_MAX and go to FALL.
REQ-024 FALL: dino_yoff -= JUMP_STEP; if the result is <= 0, clamp dino_yoff to 0 and go to GROUND; no underflow.
REQ-025 A jump_req arriving during RISE or FALL is discarded; there is no double jump.
REQ-026 RUN on tick: obst_x += step; if the result is > SCROLL_MAX, obst_x wraps to 0, score increments and obst_en advances.
REQ-027 obst_en advances from a 3-bit LFSR (x^3+x^2+1, seed 3'b001); an LFSR output of 0 is replaced by 3'b001.
REQ-028 score saturates at 1023; a wrap at 1023 leaves score at 1023.
REQ-029 Collision and wrap in the same cycle: OVER wins; score and obst_x do not update.
REQ-030 restart_req in IDLE or RUN is discarded.

Reset
REQ-031 rst_n=0 sampled at a clk edge: game_state=IDLE, jump FSM=GROUND, dino_yoff=0, obst_x=0, obst_en=3'b001, score=0, LFSR=3'b001, both requests and edge registers cleared.
REQ-032 Reset mid-jump or in OVER behaves the same as reset from IDLE; the outputs take their reset values on the next edge.

Configuration
REQ-033 With macro DINO_SPEEDUP_EN defined, step = SCROLL_STEP + min(score>>4, 3).
REQ-034 Without DINO_SPEEDUP_EN, step = SCROLL_STEP constant, and no speedup logic is built.

Structure
REQ-035 Package dino_pkg holds the game_state enum, the jump-state enum, the default parameter constants and the LFSR seed.
REQ-036 Sub-module dino_jump_fsm contains the GROUND/RISE/FALL machine and the dino_yoff register; dino_game_ctrl instantiates it once.

Verification
REQ-037 Reset, then jump_btn pulse, then 1 tick: game_state=RUN, score=0, obst_x=0.
REQ-038 RUN, jump pressed, 25 ticks: dino_yoff=50 (FALL); after 25 more ticks: dino_yoff=0 (GROUND).
REQ-039 RUN, jump pressed again at dino_yoff=20 during RISE: peak stays 50, and exactly one jump occurs.
REQ-040 RUN, 76 ticks with no collision: obst_x wraps once, score=1, obst_en!=0.
REQ-041 Collision pulse mid-frame: OVER on the next clk; values stay frozen over 10 ticks; restart_btn plus a tick gives IDLE.
REQ-042 With DINO_SPEEDUP_EN, score=16: step=5; score=64: step=7 (capped); without the macro, step=4 throughout.
